// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   sub_state_t   : FSM state encoding (IDLE, SHIFT, DONE) in 2 bits
//   sub_cnt_width : bit-step counter width for a given operand width
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Counter must hold values 0..width without wrapping.
  function automatic int sub_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_borrow_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor: x - y - bin.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial unsigned subtractor, diff = a - b, one bit per clock LSB first.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake (a minuend, b subtrahend)
//   out_valid/out_ready : result handshake
//   diff                : (a - b) mod 2^WIDTH
//   borrow              : 1 iff a < b
//   zero                : 1 iff diff == 0
module serial_borrow_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = sub_cnt_width(WIDTH);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("serial_borrow_subtractor: WIDTH must be >= 1");
    end
  endgenerate

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_borrow;
  logic             r_zero;
  logic             r_out_valid;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_dmsb;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_fs (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  // Difference bit enters at the MSB; built without a part-select so that
  // WIDTH = 1 elaborates cleanly.
  always_comb begin
    w_dmsb            = '0;
    w_dmsb[WIDTH-1]   = w_d;
    w_res_next        = (r_res >> 1) | w_dmsb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_br        <= 1'b0;
      r_borrow    <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sa     <= a;
            r_sb     <= b;
            r_res    <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_bout;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_borrow    <= w_bout;
            r_zero      <= (w_res_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so in_ready reads 0 while reset is held even though the
  // state register already sits at IDLE.
  assign in_ready  = rst_n & (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_res;
  assign borrow    = r_borrow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
module tb_serial_borrow_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] diff;
  logic       borrow;
  logic       zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] d;
    logic       bo;
    logic       z;
  } exp_t;

  exp_t q[$];

  serial_borrow_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int ua, input int ub);
    exp_t e;
    int   r;
    r    = ua - ub;
    if (r < 0) r = r + 16;
    e.d  = 4'(r);
    e.bo = (ua < ub);
    e.z  = (r == 0);
    return e;
  endfunction

  // Waits (bounded) for in_ready at a falling edge, drives the operands,
  // records the expected result, and returns 1ns after the accept edge.
  task automatic send(input logic [3:0] va, input logic [3:0] vb);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin
      $display("FAIL send_wait: in_ready=0 required 1");
      n_fail++;
      return;
    end
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    q.push_back(model(int'(va), int'(vb)));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (counted as 1) to out_valid, then
  // compares against the scoreboard head. Leaves the DUT in DONE.
  task automatic wait_result(input string name, output int edges);
    exp_t e;
    int   n;
    bit   seen;
    n    = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
      @(posedge clk);
      n++;
    end
    edges = n;
    n_tests++;
    if (!seen) begin
      $display("FAIL %s_timeout: out_valid=0 required 1", name);
      n_fail++;
      return;
    end
    n_tests++;
    if (q.size() == 0) begin
      $display("FAIL %s_scoreboard: queue empty, required an entry", name);
      n_fail++;
      return;
    end
    e = q.pop_front();
    n_tests++;
    if (diff !== e.d) begin
      $display("FAIL %s_diff: got %0d required %0d", name, diff, e.d);
      n_fail++;
    end
    n_tests++;
    if (borrow !== e.bo) begin
      $display("FAIL %s_borrow: got %0b required %0b", name, borrow, e.bo);
      n_fail++;
    end
    n_tests++;
    if (zero !== e.z) begin
      $display("FAIL %s_zero: got %0b required %0b", name, zero, e.z);
      n_fail++;
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL %s_consume: out_valid=%0b in_ready=%0b required 0/1",
               name, out_valid, in_ready);
      n_fail++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, diff, borrow, zero} !== 8'h00) begin
      $display("FAIL reset_values: in_ready=%0b out_valid=%0b diff=%0d borrow=%0b zero=%0b required all 0",
               in_ready, out_valid, diff, borrow, zero);
      n_fail++;
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_in_ready: got %0b required 1", in_ready);
      n_fail++;
    end
  endtask

  task automatic test_basic;
    int edges;
    send(4'd9, 4'd3);
    wait_result("sub_9_3", edges);
    n_tests++;
    if (edges != 5) begin
      $display("FAIL latency: got %0d edges required 5", edges);
      n_fail++;
    end
    consume("sub_9_3");
    send(4'd3, 4'd9);
    wait_result("sub_3_9", edges);
    consume("sub_3_9");
    send(4'd15, 4'd15);
    wait_result("sub_15_15", edges);
    consume("sub_15_15");
    send(4'd0, 4'd0);
    wait_result("sub_0_0", edges);
    consume("sub_0_0");
  endtask

  task automatic test_back_pressure;
    int edges;
    send(4'd12, 4'd5);
    wait_result("bp", edges);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 4'd7 ||
          borrow !== 1'b0 || zero !== 1'b0) begin
        $display("FAIL bp_hold: out_valid=%0b in_ready=%0b diff=%0d borrow=%0b zero=%0b required 1/0/7/0/0",
                 out_valid, in_ready, diff, borrow, zero);
        n_fail++;
      end
    end
    consume("bp");
  endtask

  task automatic test_ignored_input;
    int edges;
    send(4'd6, 4'd4);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    a        = 4'd1;
    b        = 4'd2;
    in_valid = 1'b1;
    q.push_back(model(1, 2));
    n_tests++;
    if (in_ready !== 1'b0) begin
      $display("FAIL ign_in_ready_shift: got %0b required 0", in_ready);
      n_fail++;
    end
    wait_result("ign_orig", edges);
    consume("ign_orig");
    // in_valid was never dropped, so the held operands go in on this edge.
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result("ign_new", edges);
    consume("ign_new");
  endtask

  task automatic test_reset_mid;
    int   edges;
    bit   spurious;
    exp_t dropped;
    send(4'd10, 4'd3);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, diff, borrow, zero} !== 8'h00) begin
      $display("FAIL rst_mid_values: in_ready=%0b out_valid=%0b diff=%0d borrow=%0b zero=%0b required all 0",
               in_ready, out_valid, diff, borrow, zero);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    if (q.size() != 0) dropped = q.pop_front();
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) spurious = 1;
    end
    n_tests++;
    if (spurious) begin
      $display("FAIL rst_mid_no_result: out_valid=1 seen required 0");
      n_fail++;
    end
    send(4'd7, 4'd5);
    wait_result("rst_mid_7_5", edges);
    consume("rst_mid_7_5");
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    rst_n     = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_back_pressure();
    test_ignored_input();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
# serial_borrow_subtractor

Bit-serial unsigned subtractor computing `diff = a - b` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart to the team's combinational ripple-carry adder, trading latency for area in datapaths that already tolerate multi-cycle arithmetic. Operands enter and results leave through valid/ready handshakes, so the block sits directly between a producer and a consumer stage.

## Interface
- `WIDTH`, default 4: operand and result width in bits. Legal range is WIDTH >= 1; elaboration fails otherwise.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: operands `a` and `b` are valid.
- `in_ready` output, 1 bit: block can accept operands.
- `a` input, WIDTH bits: minuend, unsigned.
- `b` input, WIDTH bits: subtrahend, unsigned.
- `out_valid` output, 1 bit: result is valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `diff` output, WIDTH bits: `(a - b) mod 2^WIDTH`.
- `borrow` output, 1 bit: set to 1 iff `a < b`, unsigned.
- `zero` output, 1 bit: set to 1 iff `diff == 0`.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: load the shift registers `sa <= a`, `sb <= b`; clear the borrow register `br <= 0`, `cnt <= 0`, and the result register; go to SHIFT.
- **SHIFT:** each cycle performs one bit step.
  - Difference bit: `d = sa[0] ^ sb[0] ^ br`.
  - Next borrow: `br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`.
  - Shift `d` into the result MSB, shift right.
  - Shift `sa` and `sb` right by one.
  - `cnt <= cnt + 1`.
  - When `cnt == WIDTH-1`: capture `borrow <= br_n`, go to DONE.
- **DONE:**
  - `out_valid` = 1; `diff`, `borrow` and `zero` are held stable.
  - On `out_ready`: go to IDLE.
- `in_ready` is 1 only in IDLE. There is no overlap of accept and present, so an `out_ready` in DONE never coincides with an accept on the same edge.
- `in_valid` asserted during SHIFT or DONE is ignored. The operands are not captured, and the producer must hold them until `in_ready`.
- `diff`, `borrow` and `zero` are undefined to the consumer whenever `out_valid` = 0. They may change during SHIFT.
- **Arithmetic:**
  - `diff` wraps modulo 2^WIDTH.
  - `borrow` is the final borrow out of the MSB.
  - `cnt` width is `$clog2(WIDTH+1)` and it never wraps.
- **Reset (any state, including mid-SHIFT):** go to IDLE. All outputs and internal registers are cleared, and the operation in flight is discarded with no result.

## Timing
- **Reset values:**
  - `in_ready` = 0 while `rst_n` = 0, and 1 after release (state IDLE).
  - `out_valid`, `diff`, `borrow`, `zero` = 0.
- **Latency:** the accept edge plus WIDTH SHIFT edges. `out_valid` rises WIDTH+1 edges after the accept edge; with WIDTH = 4 that is the 5th edge including the accept edge.
- **Throughput:** one result per WIDTH+2 cycles when `out_ready` is held high. The DONE→IDLE edge and the IDLE accept edge are distinct.
- **Back-pressure:** DONE is held indefinitely while `out_ready` = 0, with outputs unchanged.
- **WIDTH = 1:** SHIFT lasts exactly one cycle.

## Structure
- **Package `sub_pkg`:**
  - State typedef `sub_state_t` {IDLE, SHIFT, DONE}, encoded in 2 bits.
  - Localparam-style helper for the counter width.
- **Sub-module `full_subtractor`:** combinational; inputs `x`, `y`, `bin`; outputs `d`, `bout`. Instantiated once in the bit step.
- **Top level:** FSM, shift registers, counter and borrow flip-flop. `zero` is registered from the completed result on entry to DONE.

## Test plan
- **9 - 3, WIDTH = 4:** `a` = 9, `b` = 3 → `diff` = 6, `borrow` = 0, `zero` = 0; `out_valid` on the 5th edge after accept.
- **3 - 9 (wrap):** `a` = 3, `b` = 9 → `diff` = 10, `borrow` = 1.
- **Equal operands:** `a` = 15, `b` = 15 → `diff` = 0, `borrow` = 0, `zero` = 1. Also `a` = 0, `b` = 0 gives the same result.
- **Back-pressure:** `out_ready` = 0 for 3 cycles in DONE → outputs stable and `in_ready` = 0 throughout; the first `out_ready` edge returns the block to IDLE.
- **Ignored input:** new `in_valid` with `a` = 1, `b` = 2 asserted during SHIFT → the original result is unaffected; the new operands are accepted only after return to IDLE.
- **Reset mid-operation:** drive `rst_n` low for 1 cycle at the 2nd SHIFT cycle → all outputs are 0 immediately, no `out_valid` follows, and the next operation (7 - 5 → `diff` = 2) is correct.
